// File: rtl/nios_count_tick_counter.sv
// Avalon-MM tick counter: 4-digit BCD up/down count of timer ticks with
// compare/match, wrap detection, binary tick total and level interrupt.
module nios_count_tick_counter #(
    parameter logic [15:0] RESET_COUNT   = 16'h0000,
    parameter logic [15:0] RESET_COMPARE = 16'h9999,
    parameter bit          TICK_EDGE     = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        irq,
    output logic [15:0] count_bcd
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned DIGITS = 4;

    localparam logic [2:0] ADDR_STATUS  = 3'd0;
    localparam logic [2:0] ADDR_CONTROL = 3'd1;
    localparam logic [2:0] ADDR_COUNT   = 3'd2;
    localparam logic [2:0] ADDR_COMPARE = 3'd3;
    localparam logic [2:0] ADDR_TICKS   = 3'd4;

    logic [DATA_W-1:0] count_q, count_n;
    logic [DATA_W-1:0] compare_q, compare_n;
    logic [DATA_W-1:0] ticks_q, ticks_n;
    logic [2:0]        control_q, control_n;   // {irq_en, down, run}
    logic [1:0]        status_q, status_n;     // {wrap, match}
    logic [DATA_W-1:0] readdata_n;
    logic              tick_d;

    logic              wr, wr_status, wr_control, wr_count, wr_compare, wr_ticks;
    logic              clear, tick_ev, tick_acc, upd, wrap_ev;
    logic [DATA_W:0]   step;

    // One BCD step; MSB is the carry/borrow out of the top digit (wrap).
    function automatic logic [DATA_W:0] bcd_step(input logic [DATA_W-1:0] v,
                                                 input logic down);
        logic [DATA_W-1:0] r;
        logic              c;
        logic [3:0]        d;
        r = v;
        c = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            d = v[i*4 +: 4];
            if (c) begin
                if (!down) begin
                    if (d >= 4'd9) begin
                        r[i*4 +: 4] = 4'd0;
                        c = 1'b1;
                    end else begin
                        r[i*4 +: 4] = d + 4'd1;
                        c = 1'b0;
                    end
                end else begin
                    if (d == 4'd0) begin
                        r[i*4 +: 4] = 4'd9;
                        c = 1'b1;
                    end else if (d > 4'd9) begin
                        r[i*4 +: 4] = 4'd9;
                        c = 1'b0;
                    end else begin
                        r[i*4 +: 4] = d - 4'd1;
                        c = 1'b0;
                    end
                end
            end
        end
        return {c, r};
    endfunction

    // Next-state logic: clear strobe > count write > accepted tick.
    always_comb begin
        wr         = chipselect & ~write_n;
        wr_status  = wr && (address == ADDR_STATUS);
        wr_control = wr && (address == ADDR_CONTROL);
        wr_count   = wr && (address == ADDR_COUNT);
        wr_compare = wr && (address == ADDR_COMPARE);
        wr_ticks   = wr && (address == ADDR_TICKS);
        clear      = wr_control & writedata[3];
        tick_ev    = TICK_EDGE ? (tick & ~tick_d) : tick;
        tick_acc   = tick_ev & control_q[0];
        step       = bcd_step(count_q, control_q[1]);

        count_n   = count_q;
        compare_n = compare_q;
        control_n = control_q;
        ticks_n   = ticks_q;
        upd       = 1'b0;
        wrap_ev   = 1'b0;

        if (wr_compare) begin
            compare_n = writedata;
            upd       = 1'b1;
        end

        if (clear) begin
            count_n = '0;
        end else if (wr_count) begin
            count_n = writedata;
            upd     = 1'b1;
        end else if (tick_acc) begin
            count_n = step[DATA_W-1:0];
            wrap_ev = step[DATA_W];
            upd     = 1'b1;
            ticks_n = ticks_q + 16'd1;
        end

        if (wr_control) control_n = writedata[2:0];
        if (wr_ticks)   ticks_n   = '0;

        // Events in the same cycle as a status write win.
        status_n = wr_status ? 2'b00 : status_q;
        if (upd && (count_n == compare_n)) status_n[0] = 1'b1;
        if (wrap_ev)                       status_n[1] = 1'b1;

        case (address)
            ADDR_STATUS:  readdata_n = DATA_W'(status_q);
            ADDR_CONTROL: readdata_n = DATA_W'(control_q);
            ADDR_COUNT:   readdata_n = count_q;
            ADDR_COMPARE: readdata_n = compare_q;
            ADDR_TICKS:   readdata_n = ticks_q;
            default:      readdata_n = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q   <= RESET_COUNT;
            compare_q <= RESET_COMPARE;
            control_q <= '0;
            status_q  <= '0;
            ticks_q   <= '0;
            tick_d    <= 1'b0;
            readdata  <= '0;
        end else begin
            count_q   <= count_n;
            compare_q <= compare_n;
            control_q <= control_n;
            status_q  <= status_n;
            ticks_q   <= ticks_n;
            tick_d    <= tick;
            readdata  <= readdata_n;
        end
    end

    assign irq       = (status_q[0] | status_q[1]) & control_q[2];
    assign count_bcd = count_q;

endmodule
